// File: rtl/mips_pkg.sv
// mips_pkg: shared encodings for the EX-stage multiply/divide unit
package mips_pkg;

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    localparam logic [1:0] MV_MFHI = 2'b00;
    localparam logic [1:0] MV_MFLO = 2'b01;
    localparam logic [1:0] MV_MTHI = 2'b10;
    localparam logic [1:0] MV_MTLO = 2'b11;

    typedef enum logic [1:0] {
        MDS_IDLE = 2'd0,
        MDS_MUL  = 2'd1,
        MDS_DIV  = 2'd2,
        MDS_FIX  = 2'd3
    } mds_e;

    function automatic logic md_is_signed(input logic [1:0] op);
        return op == MD_MULT || op == MD_DIV;
    endfunction

    function automatic logic md_is_div(input logic [1:0] op);
        return op == MD_DIV || op == MD_DIVU;
    endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// muldiv_datapath: magnitude shift-add / restoring-divide accumulator with sign fixup
module muldiv_datapath
    import mips_pkg::*;
#(
    parameter int               WIDTH   = 32,
    parameter logic [WIDTH-1:0] DIV0_LO = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             step_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int W = WIDTH;

    logic [2*W-1:0] acc_q, acc_d, acc_init, mul_next, div_next, prod;
    logic [W-1:0]   dv_q, rs_q, mag_a, mag_b, quo, rem;
    logic [W:0]     mul_sum, div_up, div_diff;
    logic           is_div_q, div0_q, neg_q_q, neg_r_q;
    logic           sa, sb;

    // Work on magnitudes; the signs are remembered and applied to the result
    assign sa    = md_is_signed(op_i) & a_i[W-1];
    assign sb    = md_is_signed(op_i) & b_i[W-1];
    assign mag_a = sa ? -a_i : a_i;
    assign mag_b = sb ? -b_i : b_i;

    // Multiply keeps the multiplier in the low half; divide keeps the dividend there
    assign acc_init = md_is_div(op_i) ? {{W{1'b0}}, mag_a} : {{W{1'b0}}, mag_b};

    // Shift-add: add the multiplicand into the top half when the low bit is set, then shift right
    assign mul_sum  = {1'b0, acc_q[2*W-1:W]} + {1'b0, (acc_q[0] ? dv_q : {W{1'b0}})};
    assign mul_next = {mul_sum, acc_q[W-1:1]};

    // Restoring divide: trial-subtract from the shifted partial remainder, keep it if no borrow
    assign div_up   = acc_q[2*W-1:W-1];
    assign div_diff = div_up - {1'b0, dv_q};
    assign div_next = div_diff[W] ? {acc_q[2*W-2:0], 1'b0}
                                  : {div_diff[W-1:0], acc_q[W-2:0], 1'b1};

    // Accumulator next state: load on accept, iterate while the FSM is in MUL/DIV
    always_comb begin
        acc_d = load_i ? acc_init : step_i ? (is_div_q ? div_next : mul_next) : acc_q;
    end

    // Accumulator and per-operation context captured at the accept edge
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q    <= '0;
            dv_q     <= '0;
            rs_q     <= '0;
            is_div_q <= 1'b0;
            div0_q   <= 1'b0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
        end else begin
            acc_q <= acc_d;
            if (load_i) begin
                dv_q     <= md_is_div(op_i) ? mag_b : mag_a;
                rs_q     <= a_i;
                is_div_q <= md_is_div(op_i);
                div0_q   <= b_i == '0;
                neg_q_q  <= sa ^ sb;
                neg_r_q  <= sa;
            end
        end
    end

    // Sign fixup; divide-by-zero overrides both halves with fixed values
    assign prod = neg_q_q ? -acc_q : acc_q;
    assign quo  = neg_q_q ? -acc_q[W-1:0] : acc_q[W-1:0];
    assign rem  = neg_r_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];
    assign hi_o = !is_div_q ? prod[2*W-1:W] : div0_q ? rs_q    : rem;
    assign lo_o = !is_div_q ? prod[W-1:0]   : div0_q ? DIV0_LO : quo;

endmodule

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative MULT/DIV sequencer owning HI/LO, with move handling and stall request
module ex_muldiv_unit
    import mips_pkg::*;
#(
    parameter int               WIDTH   = 32,
    parameter logic [WIDTH-1:0] DIV0_LO = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             StartE,
    input  logic [1:0]       MdOpE,
    input  logic             MoveE,
    input  logic [1:0]       MoveOpE,
    input  logic             FlushE,
    input  logic [WIDTH-1:0] ReadData1E,
    input  logic [WIDTH-1:0] ReadData2E,
    output logic [WIDTH-1:0] HiLoOutE,
    output logic             MdStallE,
    output logic             BusyE,
    output logic [WIDTH-1:0] HiE,
    output logic [WIDTH-1:0] LoE
);

    localparam int             CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    mds_e             state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, res_hi, res_lo;
    logic             busy, step, fix, accept, mv_ok;

    assign accept = StartE & ~FlushE & (state_q == MDS_IDLE);
    assign mv_ok  = MoveE & ~StartE & ~FlushE & (state_q == MDS_IDLE);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= MDS_IDLE;
        else     state_q <= state_d;
    end

    // Next state: one iteration per cycle, leave MUL/DIV on the last count, then one FIX cycle
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            MDS_IDLE: state_d = accept ? (md_is_div(MdOpE) ? MDS_DIV : MDS_MUL) : MDS_IDLE;
            MDS_MUL,
            MDS_DIV:  state_d = (cnt_q == LAST) ? MDS_FIX : state_q;
            MDS_FIX:  state_d = MDS_IDLE;
            default:  state_d = MDS_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy = state_q != MDS_IDLE;
        step = state_q == MDS_MUL || state_q == MDS_DIV;
        fix  = state_q == MDS_FIX;
    end

    // Iteration counter advances only while iterating
    always_comb begin
        cnt_d = step ? cnt_q + 1'b1 : '0;
    end

    // Iteration counter register
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    // HI/LO take the result at the end of FIX, or a move-to when idle
    always_comb begin
        hi_d = fix ? res_hi : (mv_ok && MoveOpE == MV_MTHI) ? ReadData1E : hi_q;
        lo_d = fix ? res_lo : (mv_ok && MoveOpE == MV_MTLO) ? ReadData1E : lo_q;
    end

    // Architectural HI/LO registers
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    muldiv_datapath #(
        .WIDTH   (WIDTH),
        .DIV0_LO (DIV0_LO)
    ) u_dp (
        .clk    (clk),
        .rst    (rst),
        .load_i (accept),
        .step_i (step),
        .op_i   (MdOpE),
        .a_i    (ReadData1E),
        .b_i    (ReadData2E),
        .hi_o   (res_hi),
        .lo_o   (res_lo)
    );

    assign BusyE    = busy;
    assign MdStallE = busy & (StartE | MoveE) & ~FlushE;
    assign HiE      = hi_q;
    assign LoE      = lo_q;
    assign HiLoOutE = !MoveE                ? '0   :
                      (MoveOpE == MV_MFHI) ? hi_q :
                      (MoveOpE == MV_MFLO) ? lo_q : '0;

endmodule
